// File: rtl/ysyx_23060124_mem_stage.sv
// ysyx_23060124_mem_stage: memory/writeback stage behind the EXU.
// Define YSYX_23060124_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module ysyx_23060124_mem_stage #(
    parameter int ISA_WIDTH = 32,
    parameter int OPT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [ISA_WIDTH-1:0] i_res,
    input  logic [ISA_WIDTH-1:0] i_src2,
    input  logic [OPT_WIDTH-1:0] i_load_opt,
    input  logic [OPT_WIDTH-1:0] i_store_opt,
    input  logic [4:0]           i_rd,
    input  logic                 i_wen,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ISA_WIDTH-1:0] o_mem_addr,
    output logic [ISA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_wstrb,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [ISA_WIDTH-1:0] i_mem_rdata,
    output logic                 o_wb_valid,
    output logic [4:0]           o_wb_rd,
    output logic [ISA_WIDTH-1:0] o_wb_data,
    output logic                 o_wb_wen,
    output logic                 o_fault
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 is_ld;
    logic                 is_st;
    logic                 is_mem;
    logic                 sext_in;
    logic [1:0]           size_in;
    logic                 misalign;
    logic [ISA_WIDTH-1:0] res_q;
    logic [ISA_WIDTH-1:0] src2_q;
    logic [ISA_WIDTH-1:0] data_q;
    logic [4:0]           rd_q;
    logic [1:0]           size_q;
    logic                 sext_q;
    logic                 ld_q;
    logic                 st_q;
    logic                 wen_q;
    logic [4:0]           ld_sh;
    logic [ISA_WIDTH-1:0] ld_word;
    logic [ISA_WIDTH-1:0] ld_data;
    logic [ISA_WIDTH-1:0] st_data;
    logic [3:0]           st_strb;

    assign accept = i_valid & (state == S_IDLE);
    assign is_mem = is_ld | is_st;

    // size: 0 byte, 1 half, 2 word; loads win over stores
    always_comb begin
        is_ld   = 1'b0;
        is_st   = 1'b0;
        sext_in = 1'b0;
        size_in = 2'd2;
        case (i_load_opt)
            OPT_WIDTH'(1): begin is_ld = 1'b1; size_in = 2'd0; sext_in = 1'b1; end
            OPT_WIDTH'(2): begin is_ld = 1'b1; size_in = 2'd1; sext_in = 1'b1; end
            OPT_WIDTH'(3): begin is_ld = 1'b1; size_in = 2'd2; end
            OPT_WIDTH'(4): begin is_ld = 1'b1; size_in = 2'd0; end
            OPT_WIDTH'(5): begin is_ld = 1'b1; size_in = 2'd1; end
            default: begin
                case (i_store_opt)
                    OPT_WIDTH'(1): begin is_st = 1'b1; size_in = 2'd0; end
                    OPT_WIDTH'(2): begin is_st = 1'b1; size_in = 2'd1; end
                    OPT_WIDTH'(3): begin is_st = 1'b1; size_in = 2'd2; end
                    default: ;
                endcase
            end
        endcase
    end

`ifdef YSYX_23060124_MISALIGN_TRAP_EN
    logic fault_q;

    assign misalign = is_mem & (((size_in == 2'd1) & i_res[0]) |
                                ((size_in == 2'd2) & (|i_res[1:0])));

    always_ff @(posedge clk) begin
        if (i_rst)       fault_q <= 1'b0;
        else if (accept) fault_q <= misalign;
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = (is_mem & ~misalign) ? S_REQ : S_WB;
            S_REQ:   if (i_mem_gnt) state_nxt = S_WAIT;
            S_WAIT:  if (i_mem_rvalid) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // halfword uses a[1] only, word never shifts
    always_comb begin
        case (size_q)
            2'd0:    ld_sh = {res_q[1:0], 3'b000};
            2'd1:    ld_sh = {res_q[1], 4'b0000};
            default: ld_sh = 5'd0;
        endcase
        ld_word = i_mem_rdata >> ld_sh;
        case (size_q)
            2'd0:    ld_data = {{(ISA_WIDTH-8){sext_q & ld_word[7]}}, ld_word[7:0]};
            2'd1:    ld_data = {{(ISA_WIDTH-16){sext_q & ld_word[15]}}, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0: begin
                st_strb = 4'b0001 << res_q[1:0];
                st_data = {4{src2_q[7:0]}};
            end
            2'd1: begin
                st_strb = 4'b0011 << {res_q[1], 1'b0};
                st_data = {2{src2_q[15:0]}};
            end
            default: begin
                st_strb = 4'hF;
                st_data = src2_q;
            end
        endcase
        if (!st_q) st_strb = 4'h0;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            res_q  <= '0;
            src2_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
            size_q <= '0;
            sext_q <= 1'b0;
            ld_q   <= 1'b0;
            st_q   <= 1'b0;
            wen_q  <= 1'b0;
        end else if (accept) begin
            res_q  <= i_res;
            src2_q <= i_src2;
            data_q <= i_res;
            rd_q   <= i_rd;
            size_q <= size_in;
            sext_q <= sext_in;
            ld_q   <= is_ld;
            st_q   <= is_st;
            wen_q  <= i_wen & (|i_rd) & ~is_st & ~misalign;
        end else if ((state == S_WAIT) && i_mem_rvalid && ld_q) begin
            data_q <= ld_data;
        end
    end

    always_comb begin
        o_ready     = (state == S_IDLE);
        o_mem_req   = (state == S_REQ);
        o_mem_we    = (state == S_REQ) & st_q;
        o_mem_addr  = {res_q[ISA_WIDTH-1:2], 2'b00};
        o_mem_wdata = st_data;
        o_mem_wstrb = st_strb;
        o_wb_valid  = (state == S_WB);
        o_wb_rd     = rd_q;
        o_wb_data   = data_q;
        o_wb_wen    = (state == S_WB) & wen_q;
`ifdef YSYX_23060124_MISALIGN_TRAP_EN
        o_fault     = (state == S_WB) & fault_q;
`else
        o_fault     = 1'b0;
`endif
    end
endmodule

// File: tb/tb_ysyx_23060124_mem_stage.sv
// tb_ysyx_23060124_mem_stage: scoreboard bench for the memory stage.
// Honours YSYX_23060124_MISALIGN_TRAP_EN when computing expectations.
module tb_ysyx_23060124_mem_stage;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_res = '0;
    logic [31:0] i_src2 = '0;
    logic [3:0]  i_load_opt = '0;
    logic [3:0]  i_store_opt = '0;
    logic [4:0]  i_rd = '0;
    logic        i_wen = 1'b0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_wb_wen;
    logic        o_fault;

    always #5 clk = ~clk;

    ysyx_23060124_mem_stage dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_res(i_res), .i_src2(i_src2), .i_load_opt(i_load_opt),
        .i_store_opt(i_store_opt), .i_rd(i_rd), .i_wen(i_wen),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_wb_wen(o_wb_wen), .o_fault(o_fault)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic        flt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [3:0] op,
                                             input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            4'd1:    return {{24{b[7]}}, b};
            4'd2:    return {{16{h[15]}}, h};
            4'd4:    return {24'h0, b};
            4'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (o_wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", o_wb_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_rd", o_wb_rd, mon_e.rd);
                check("wb_data", o_wb_data, mon_e.data);
                check("wb_wen", o_wb_wen, mon_e.wen);
                check("wb_fault", o_fault, mon_e.flt);
                check("wb_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic mem_op(input logic [3:0] ld, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] s2,
                          input logic [4:0] rd, input logic wen,
                          input int gd, input logic [31:0] rdata);
        logic        is_ld, is_st, mem, flt;
        logic [1:0]  sz;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        exp_t        e;
        int          n, reqs;
        is_ld = (ld >= 4'd1) && (ld <= 4'd5);
        is_st = !is_ld && (st >= 4'd1) && (st <= 4'd3);
        mem   = is_ld || is_st;
        if (is_ld) sz = (ld == 4'd1 || ld == 4'd4) ? 2'd0 : (ld == 4'd3) ? 2'd2 : 2'd1;
        else       sz = (st == 4'd1) ? 2'd0 : (st == 4'd2) ? 2'd1 : 2'd2;
        flt = 1'b0;
`ifdef YSYX_23060124_MISALIGN_TRAP_EN
        flt = mem && (((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00)));
`endif
        case (sz)
            2'd0: begin estrb = 4'b0001 << a[1:0]; ewdata = {4{s2[7:0]}}; end
            2'd1: begin estrb = a[1] ? 4'b1100 : 4'b0011; ewdata = {2{s2[15:0]}}; end
            default: begin estrb = 4'hF; ewdata = s2; end
        endcase
        @(negedge clk);
        n = cyc;
        i_valid = 1'b1; i_res = a; i_src2 = s2; i_rd = rd; i_wen = wen;
        i_load_opt = ld; i_store_opt = st;
        e.rd   = rd;
        e.flt  = flt;
        e.data = (is_ld && !flt) ? ld_model(ld, a[1:0], rdata) : a;
        e.wen  = wen && (rd != 5'd0) && !is_st && !flt;
        e.cyc  = (mem && !flt) ? n + 3 + gd : n + 1;
        sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0; i_res = $urandom; i_src2 = $urandom;
        i_rd = 5'($urandom); i_load_opt = 4'($urandom); i_store_opt = 4'($urandom);
        if (!(mem && !flt)) begin
            check("no_req", o_mem_req, 1'b0);
            @(negedge clk);
        end else begin
            reqs = 0;
            check("mem_addr", o_mem_addr, {a[31:2], 2'b00});
            check("mem_we", o_mem_we, is_st);
            check("mem_wstrb", o_mem_wstrb, is_st ? estrb : 4'h0);
            if (is_st) check("mem_wdata", o_mem_wdata, ewdata);
            for (int i = 0; i < gd; i++) begin
                reqs += int'(o_mem_req);
                i_mem_rvalid = 1'b1; i_mem_rdata = $urandom;
                @(negedge clk);
            end
            check("mem_addr_held", o_mem_addr, {a[31:2], 2'b00});
            reqs += int'(o_mem_req);
            i_mem_rvalid = 1'b0; i_mem_gnt = 1'b1;
            @(negedge clk);
            i_mem_gnt = 1'b0;
            check("req_drop", o_mem_req, 1'b0);
            check("req_cycles", reqs, gd + 1);
            i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
            @(negedge clk);
            i_mem_rvalid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        check("rst_ready", o_ready, 1'b1);
        check("rst_req", o_mem_req, 1'b0);
        check("rst_we", o_mem_we, 1'b0);
        check("rst_wb_valid", o_wb_valid, 1'b0);
        check("rst_wb_wen", o_wb_wen, 1'b0);
        check("rst_fault", o_fault, 1'b0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_wstrb", o_mem_wstrb, 4'h0);

        mem_op(4'd0, 4'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        mem_op(4'd1, 4'd0, 32'h0000_1003, 32'h0, 5'd6, 1'b1, 0, 32'h80FF_0000);
        mem_op(4'd0, 4'd2, 32'h0000_2002, 32'hABCD_5678, 5'd7, 1'b1, 3, 32'h0);
        mem_op(4'd5, 4'd0, 32'h0000_2001, 32'h0, 5'd8, 1'b1, 1, 32'h1234_9ABC);
        mem_op(4'd2, 4'd0, 32'h0000_1006, 32'h0, 5'd9, 1'b1, 2, 32'h8001_0000);
        mem_op(4'd4, 4'd0, 32'h0000_1001, 32'h0, 5'd10, 1'b1, 0, 32'h0000_F100);
        mem_op(4'd3, 4'd0, 32'h0000_0004, 32'h0, 5'd11, 1'b1, 0, 32'hCAFE_F00D);
        mem_op(4'd0, 4'd1, 32'h0000_0005, 32'h1122_33EE, 5'd12, 1'b1, 1, 32'h0);
        mem_op(4'd0, 4'd3, 32'h0000_0008, 32'h5A5A_A5A5, 5'd13, 1'b1, 0, 32'h0);
        mem_op(4'd0, 4'd3, 32'h0000_000A, 32'h0F0F_F0F0, 5'd13, 1'b1, 0, 32'h0);
        mem_op(4'd3, 4'd3, 32'h0000_0020, 32'h1111_1111, 5'd14, 1'b1, 0, 32'hDEAD_BEEF);
        mem_op(4'd7, 4'd9, 32'h0000_0BAD, 32'h0, 5'd15, 1'b1, 0, 32'h0);
        mem_op(4'd3, 4'd0, 32'h0000_0010, 32'h0, 5'd0, 1'b1, 0, 32'h7777_7777);
        mem_op(4'd0, 4'd0, 32'h0000_0042, 32'h0, 5'd16, 1'b0, 0, 32'h0);

        @(negedge clk);
        n = cyc;
        i_valid = 1'b1; i_load_opt = 4'd0; i_store_opt = 4'd0;
        i_res = 32'hAAAA_0001; i_rd = 5'd3; i_wen = 1'b1;
        sb.push_back('{rd: 5'd3, data: 32'hAAAA_0001, wen: 1'b1, flt: 1'b0, cyc: n + 1});
        sb.push_back('{rd: 5'd7, data: 32'hBBBB_0002, wen: 1'b1, flt: 1'b0, cyc: n + 3});
        @(negedge clk);
        check("b2b_busy", o_ready, 1'b0);
        i_res = 32'hBBBB_0002; i_rd = 5'd7;
        @(negedge clk);
        check("b2b_ready", o_ready, 1'b1);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);

        i_valid = 1'b1; i_load_opt = 4'd3; i_store_opt = 4'd0;
        i_res = 32'h0000_3000; i_rd = 5'd9; i_wen = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check("rst_mid_req", o_mem_req, 1'b1);
        i_mem_gnt = 1'b1;
        @(negedge clk);
        i_mem_gnt = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        check("rst_mid_req_drop", o_mem_req, 1'b0);
        check("rst_mid_ready", o_ready, 1'b1);
        check("rst_mid_wb", o_wb_valid, 1'b0);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1357_9BDF;
        repeat (2) @(negedge clk);
        i_mem_rvalid = 1'b0;
        check("rst_late_ready", o_ready, 1'b1);
        check("rst_late_req", o_mem_req, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
